// File: rtl/logic_unit_pkg.sv
// Shared opcode encodings, FSM state constants and the requester-selection
// helper for the logic unit arbiter.
package logic_unit_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] op_t;

    localparam op_t OP_NOT = 2'b00;
    localparam op_t OP_AND = 2'b01;
    localparam op_t OP_OR  = 2'b10;
    localparam op_t OP_XOR = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // First asserted request at or after ptr, wrapping 3->0. Result is only
    // meaningful when req is non-zero.
    function automatic logic [1:0] pick_winner(input logic [NUM_REQ-1:0] req,
                                               input logic [1:0]         ptr);
        logic [1:0] idx;
        logic       found;
        pick_winner = ptr;
        found       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                pick_winner = idx;
                found       = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/logic_op_unit.sv
// Combinational bitwise gate evaluator: NOT / AND / OR / XOR over WIDTH bits.
module logic_op_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Four-requester arbiter feeding a single shared logic_op_unit through an
// IDLE -> EXEC -> DONE sequence. Define FIXED_PRIO_EN for lowest-index-wins.
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [2*NUM_REQ-1:0]   op,
    input  logic [NUM_REQ*WIDTH-1:0] a,
    input  logic [NUM_REQ*WIDTH-1:0] b,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   busy,
    output logic                   res_valid,
    output logic [WIDTH-1:0]       res_data,
    output logic [1:0]             res_id
);

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         win_q, win_d;
    op_t                op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic [1:0]         res_id_q, res_id_d;

    logic [1:0]         winner;
    logic [WIDTH-1:0]   op_y;

`ifdef FIXED_PRIO_EN
    assign winner = pick_winner(req, 2'd0);
`else
    assign winner = pick_winner(req, ptr_q);
`endif

    // Operands come from the latched copy, so input changes after the grant
    // cycle cannot disturb the result in flight.
    logic_op_unit #(.WIDTH(WIDTH)) u_op (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (op_y)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        gnt_d       = '0;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    win_d   = winner;
                    gnt_d   = NUM_REQ'(1) << winner;
                    state_d = ST_EXEC;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (winner == 2'(i)) begin
                            op_d = op[2*i +: 2];
                            a_d  = a[WIDTH*i +: WIDTH];
                            b_d  = b[WIDTH*i +: WIDTH];
                        end
                    end
                end
            end
            ST_EXEC: begin
                res_data_d = op_y;
                res_id_d   = win_q;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                // Strobe is registered here so it appears the cycle after
                // DONE, when the FSM is already back in IDLE.
                res_valid_d = 1'b1;
`ifdef FIXED_PRIO_EN
                ptr_d = 2'd0;
`else
                ptr_d = win_q + 2'd1;
`endif
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd0;
            win_q       <= 2'd0;
            op_q        <= OP_NOT;
            a_q         <= '0;
            b_q         <= '0;
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            gnt_q       <= gnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_gnt_rv_excl: assert property (@(posedge clk) disable iff (rst) !(|gnt_q && res_valid_q));

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits.
REQ-002 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Port req, input, 4: request per requester; bit i belongs to requester i.
REQ-005 Port op, input, 8: 2-bit opcode per requester; op[2i+1:2i] belongs to requester i.
REQ-006 Port a, input, 4*WIDTH: operand A per requester, slice i at a[WIDTH*i +: WIDTH].
REQ-007 Port b, input, 4*WIDTH: operand B per requester, same slicing as a.
REQ-008 Port gnt, output, 4: one-hot grant pulse.
REQ-009 Port busy, output, 1: high whenever the state is not IDLE.
REQ-010 Port res_valid, output, 1: one-cycle result strobe.
REQ-011 Port res_data, output, WIDTH: result value, qualified by res_valid.
REQ-012 Port res_id, output, 2: index of the requester that owns res_data.

Function
REQ-013 Opcodes SHALL be: 00 NOT (~A, B ignored), 01 AND, 10 OR, 11 XOR; bitwise over WIDTH bits.
REQ-014 FSM states SHALL be IDLE, EXEC and DONE.
REQ-015 IDLE with req==0 SHALL stay in IDLE.
REQ-016 IDLE with req!=0 SHALL select one winner, register gnt=one-hot(winner) for exactly one cycle, latch the winner's op, a and b, and go to EXEC.
REQ-017 EXEC SHALL compute the latched operation, register it into res_data, register winner into res_id, and go to DONE.
REQ-018 DONE SHALL hold res_valid=1 for exactly one cycle, update the priority pointer, and return to IDLE.
REQ-019 Latency SHALL be fixed: gnt visible in cycle N, res_valid in cycle N+2, next gnt no earlier than cycle N+3.
REQ-020 Round-robin: the search SHALL start at pointer ptr and wrap 3->0; after DONE, ptr = winner+1 mod 4.
REQ-021 Operands SHALL be sampled only in the grant cycle; changes to a, b, op or req afterwards SHALL NOT affect the result in flight.
REQ-022 Requesters SHALL deassert req in the cycle after seeing gnt; a req still high in IDLE is treated as a new request.
REQ-023 res_data and res_id SHALL hold their last value outside res_valid.
REQ-024 gnt and res_valid SHALL never be high in the same cycle.
REQ-025 busy SHALL be high in EXEC and DONE.

Reset
REQ-026 rst high SHALL force state=IDLE, gnt=0, res_valid=0, res_data=0, res_id=0 and ptr=0 on the next edge, in any state.
REQ-027 Reset during EXEC or DONE SHALL discard the in-flight result with no res_valid pulse.

Configuration
REQ-028 With FIXED_PRIO_EN defined, selection SHALL be fixed priority: lowest index wins, and ptr is unused and held at 0.
REQ-029 Without FIXED_PRIO_EN, selection SHALL be round-robin per REQ-020.

Structure
REQ-030 Package logic_unit_pkg SHALL hold the opcode constants (OP_NOT, OP_AND, OP_OR, OP_XOR), the FSM state typedef, and NUM_REQ=4.
REQ-031 The combinational gate evaluation SHALL be the sub-module logic_op_unit (op, a, b -> y, WIDTH-parameterised), instantiated once.

Verification
REQ-032 After reset, req=0001, op0=00, a0=8'h0F -> gnt=0001 in cycle 1, res_valid in cycle 3 with res_data=8'hF0, res_id=0.
REQ-033 All four requesters held high continuously (round-robin build) -> grant order 0,1,2,3,0 with one grant every 3 cycles.
REQ-034 Same stimulus with FIXED_PRIO_EN -> gnt=0001 on every grant.
REQ-035 Requester 2: op=11, a=8'hAA, b=8'hFF, then a changed to 8'h00 in the EXEC cycle -> res_data=8'h55, res_id=2.
REQ-036 rst asserted during EXEC -> no res_valid pulse; all outputs 0; next grant starts from requester 0.
REQ-037 Pointer wrap: ptr=3 with req=1001 -> requester 3 granted first, then requester 0.
